// File: rtl/sigmoid_pkg.sv
// Shared types and defaults for the bf16 sigmoid result path.
package sigmoid_pkg;

    // One buffered sigmoid result plus its end-of-vector tag.
    typedef struct packed {
        logic        last;
        logic [15:0] data;
    } resbuf_entry_t;

    // Default latency of the pipelined sigmoid unit (valid_in -> valid_out).
    localparam int SIGMOID_PIPE_LAT = 5;

endpackage : sigmoid_pkg

// File: rtl/sigmoid_result_buffer_fifo.sv
// bf16_sync_fifo: first-word fall-through synchronous FIFO of resbuf_entry_t.
// A push while full is accepted only when a pop happens in the same cycle.
// Storage is not reset; only pointers and occupancy are.
module bf16_sync_fifo
    import sigmoid_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  resbuf_entry_t              wdata_i,
    output resbuf_entry_t              rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    resbuf_entry_t   mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q,  count_d;
    logic            wr_en;
    logic            rd_en;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign rd_en = pop_i & ~empty_o;
    assign wr_en = push_i & (~full_o | rd_en);

    // Pointer and occupancy next-state; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage, written without reset.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule : bf16_sync_fifo

// File: rtl/sigmoid_result_buffer.sv
// sigmoid_result_buffer: captures every sigmoid result (the pipe has no
// backpressure), tags end-of-vector elements and presents them on a
// valid/ready port. credit_ok tells the issuer whether the FIFO plus the
// elements still in flight leave room for one more launch.
// Optional feature macro: SIGMOID_RESBUF_STATS_EN adds pop/vector counters.
module sigmoid_result_buffer
    import sigmoid_pkg::*;
#(
    parameter int DEPTH    = 8,
    parameter int PIPE_LAT = SIGMOID_PIPE_LAT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       issue_in,
    output logic                       credit_ok,
    input  logic                       res_valid_in,
    input  logic [15:0]                res_data_in,
    input  logic [15:0]                vec_len,
    output logic                       valid_out,
    input  logic                       ready_in,
    output logic [15:0]                data_out,
    output logic                       last_out,
    output logic [$clog2(DEPTH+1)-1:0] count_out,
`ifdef SIGMOID_RESBUF_STATS_EN
    output logic [31:0]                elem_count_out,
    output logic [31:0]                vec_count_out,
`endif
    output logic                       overflow_out
);

    localparam int IW = $clog2(PIPE_LAT+1);

    logic           push, pop, full, empty, push_acc, drop;
    logic           is_last;
    logic [15:0]    vec_len_eff;
    logic [15:0]    elem_cnt_q, elem_cnt_d;
    logic [IW-1:0]  inflight_q, inflight_d;
    logic           ovf_q, ovf_d;
    logic [31:0]    occupancy;
    resbuf_entry_t  wr_entry, rd_entry;

    assign push     = res_valid_in;
    assign pop      = valid_out & ready_in;
    assign push_acc = push & (~full | pop);
    assign drop     = push & full & ~pop;

    // vec_len of 0 behaves as 1, so every element is a vector end.
    assign vec_len_eff = (vec_len == 16'd0) ? 16'd1 : vec_len;
    assign is_last     = (elem_cnt_q >= (vec_len_eff - 16'd1));
    assign wr_entry    = '{last: is_last, data: res_data_in};

    bf16_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (wr_entry),
        .rdata_o (rd_entry),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count_out)
    );

    // Head is masked while empty so stale storage never shows after reset.
    assign valid_out    = ~empty;
    assign data_out     = empty ? 16'd0 : rd_entry.data;
    assign last_out     = ~empty & rd_entry.last;
    assign overflow_out = ovf_q;

    // Credit uses registered occupancy only: no path from ready_in or issue_in.
    assign occupancy = 32'(count_out) + 32'(inflight_q);
    assign credit_ok = (occupancy < 32'(DEPTH));

    // Inflight tracking, last-tag counter and sticky error next-state.
    always_comb begin
        inflight_d = inflight_q;
        elem_cnt_d = elem_cnt_q;
        ovf_d      = ovf_q | drop;
        case ({issue_in, res_valid_in})
            2'b10: begin
                if (inflight_q == IW'(PIPE_LAT)) ovf_d = 1'b1;
                else                             inflight_d = inflight_q + IW'(1);
            end
            2'b01: begin
                if (inflight_q == '0) ovf_d = 1'b1;
                else                  inflight_d = inflight_q - IW'(1);
            end
            default: inflight_d = inflight_q;
        endcase
        if (push_acc) elem_cnt_d = is_last ? 16'd0 : elem_cnt_q + 16'd1;
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            inflight_q <= '0;
            elem_cnt_q <= '0;
            ovf_q      <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            elem_cnt_q <= elem_cnt_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef SIGMOID_RESBUF_STATS_EN
    logic [31:0] elem_count_q, vec_count_q;

    // Popped-element and completed-vector counters, wrapping at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            elem_count_q <= '0;
            vec_count_q  <= '0;
        end else if (pop) begin
            elem_count_q <= elem_count_q + 32'd1;
            if (last_out) vec_count_q <= vec_count_q + 32'd1;
        end
    end

    assign elem_count_out = elem_count_q;
    assign vec_count_out  = vec_count_q;
`endif

endmodule : sigmoid_result_buffer

// File: tb/tb_sigmoid_result_buffer.sv
// Directed self-checking bench for sigmoid_result_buffer (DEPTH=8, PIPE_LAT=5).
module tb_sigmoid_result_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_in;
    logic        credit_ok;
    logic        res_valid_in;
    logic [15:0] res_data_in;
    logic [15:0] vec_len;
    logic        valid_out;
    logic        ready_in;
    logic [15:0] data_out;
    logic        last_out;
    logic [3:0]  count_out;
    logic        overflow_out;
`ifdef SIGMOID_RESBUF_STATS_EN
    logic [31:0] elem_count_out;
    logic [31:0] vec_count_out;
`endif

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sigmoid_result_buffer #(.DEPTH(8), .PIPE_LAT(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_in     (issue_in),
        .credit_ok    (credit_ok),
        .res_valid_in (res_valid_in),
        .res_data_in  (res_data_in),
        .vec_len      (vec_len),
        .valid_out    (valid_out),
        .ready_in     (ready_in),
        .data_out     (data_out),
        .last_out     (last_out),
        .count_out    (count_out),
`ifdef SIGMOID_RESBUF_STATS_EN
        .elem_count_out (elem_count_out),
        .vec_count_out  (vec_count_out),
`endif
        .overflow_out (overflow_out)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        issue_in = 0; res_valid_in = 0; ready_in = 0; res_data_in = 0;
        rst = 1;
        step;
        step;
        rst = 0;
    endtask

    // Issue and result in the same cycle keeps inflight unchanged and legal.
    task automatic push1(input logic [15:0] d);
        issue_in = 1; res_valid_in = 1; res_data_in = d;
        step;
        issue_in = 0; res_valid_in = 0;
    endtask

    task automatic test_reset;
        vec_len = 16'd1;
        do_reset;
        n_vec++; if (valid_out !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0b want 0", valid_out); end
        n_vec++; if (count_out !== 4'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", count_out); end
        n_vec++; if (credit_ok !== 1'b1) begin n_err++; $display("FAIL rst_credit got %0b want 1", credit_ok); end
        n_vec++; if (overflow_out !== 1'b0) begin n_err++; $display("FAIL rst_ovf got %0b want 0", overflow_out); end
        n_vec++; if (data_out !== 16'h0 || last_out !== 1'b0) begin n_err++; $display("FAIL rst_head got %h/%0b want 0/0", data_out, last_out); end
    endtask

    task automatic test_credit_stall;
        int iss;
        do_reset;
        vec_len = 16'd1;
        for (int c = 0; c < 13; c++) begin
            issue_in     = (c < 8);
            res_valid_in = (c >= 5);
            res_data_in  = 16'h3F00 + 16'(c);
            step;
            // count + inflight equals issues so far, since results never exceed issues
            iss = (c < 8) ? c + 1 : 8;
            n_vec++;
            if (credit_ok !== (iss < 8)) begin
                n_err++; $display("FAIL credit_c%0d got %0b want %0b", c, credit_ok, (iss < 8));
            end
        end
        issue_in = 0; res_valid_in = 0;
        n_vec++; if (count_out !== 4'd8) begin n_err++; $display("FAIL stall_count got %0d want 8", count_out); end
        n_vec++; if (overflow_out !== 1'b0) begin n_err++; $display("FAIL stall_ovf got %0b want 0", overflow_out); end
        n_vec++; if (data_out !== 16'h3F05) begin n_err++; $display("FAIL stall_head got %h want 3f05", data_out); end
        ready_in = 1;
        step;
        ready_in = 0;
        n_vec++; if (count_out !== 4'd7) begin n_err++; $display("FAIL stall_pop_count got %0d want 7", count_out); end
        n_vec++; if (credit_ok !== 1'b1) begin n_err++; $display("FAIL stall_pop_credit got %0b want 1", credit_ok); end
    endtask

    task automatic test_ordering;
        logic [15:0] exp [4];
        exp[0] = 16'h3F00; exp[1] = 16'h3F3B; exp[2] = 16'h3F62; exp[3] = 16'h3F74;
        do_reset;
        vec_len = 16'd1;
        push1(exp[0]);
        n_vec++; if (valid_out !== 1'b1 || data_out !== exp[0]) begin n_err++; $display("FAIL fwft got %0b/%h want 1/%h", valid_out, data_out, exp[0]); end
        push1(exp[1]);
        push1(exp[2]);
        ready_in = 1;
        push1(exp[3]);
        n_vec++; if (count_out !== 4'd3) begin n_err++; $display("FAIL simul_count got %0d want 3", count_out); end
        for (int i = 1; i < 4; i++) begin
            n_vec++;
            if (data_out !== exp[i]) begin n_err++; $display("FAIL order_%0d got %h want %h", i, data_out, exp[i]); end
            step;
        end
        ready_in = 0;
        n_vec++; if (valid_out !== 1'b0 || count_out !== 4'd0) begin n_err++; $display("FAIL order_empty got %0b/%0d want 0/0", valid_out, count_out); end
`ifdef SIGMOID_RESBUF_STATS_EN
        n_vec++; if (elem_count_out !== 32'd4 || vec_count_out !== 32'd4) begin n_err++; $display("FAIL stats_order got %0d/%0d want 4/4", elem_count_out, vec_count_out); end
`endif
    endtask

    task automatic test_last_tag;
        logic exp_last;
        do_reset;
        vec_len = 16'd3;
        for (int i = 1; i <= 7; i++) push1(16'h4000 + 16'(i));
        ready_in = 1;
        for (int i = 1; i <= 7; i++) begin
            exp_last = (i == 3) || (i == 6);
            n_vec++;
            if (last_out !== exp_last || data_out !== 16'h4000 + 16'(i)) begin
                n_err++; $display("FAIL last3_e%0d got %0b/%h want %0b/%h", i, last_out, data_out, exp_last, 16'h4000 + 16'(i));
            end
            step;
        end
        ready_in = 0;
        vec_len = 16'd0;
        for (int i = 0; i < 3; i++) push1(16'h4100 + 16'(i));
        ready_in = 1;
        for (int i = 0; i < 3; i++) begin
            n_vec++;
            if (last_out !== 1'b1) begin n_err++; $display("FAIL last0_e%0d got %0b want 1", i, last_out); end
            step;
        end
        ready_in = 0;
    endtask

    task automatic test_overflow;
        do_reset;
        vec_len = 16'd1;
        for (int i = 0; i < 8; i++) push1(16'h3F00 + 16'(i));
        n_vec++; if (overflow_out !== 1'b0 || count_out !== 4'd8) begin n_err++; $display("FAIL full_pre got ovf %0b cnt %0d want 0/8", overflow_out, count_out); end
        push1(16'h3F7E);
        n_vec++; if (count_out !== 4'd8) begin n_err++; $display("FAIL drop_count got %0d want 8", count_out); end
        n_vec++; if (overflow_out !== 1'b1) begin n_err++; $display("FAIL drop_ovf got %0b want 1", overflow_out); end
        ready_in = 1;
        for (int i = 0; i < 8; i++) begin
            n_vec++;
            if (data_out !== 16'h3F00 + 16'(i)) begin n_err++; $display("FAIL drain_%0d got %h want %h", i, data_out, 16'h3F00 + 16'(i)); end
            step;
        end
        ready_in = 0;
        n_vec++; if (valid_out !== 1'b0 || overflow_out !== 1'b1) begin n_err++; $display("FAIL sticky got v%0b ovf %0b want 0/1", valid_out, overflow_out); end
        do_reset;
        n_vec++; if (overflow_out !== 1'b0) begin n_err++; $display("FAIL ovf_clear got %0b want 0", overflow_out); end
    endtask

    task automatic test_inflight_errors;
        do_reset;
        res_valid_in = 1; res_data_in = 16'h3C00;
        step;
        res_valid_in = 0;
        n_vec++; if (overflow_out !== 1'b1) begin n_err++; $display("FAIL underflow got %0b want 1", overflow_out); end
        do_reset;
        for (int i = 0; i < 6; i++) begin issue_in = 1; step; end
        issue_in = 0;
        n_vec++; if (overflow_out !== 1'b1) begin n_err++; $display("FAIL inflight_sat got %0b want 1", overflow_out); end
        // saturated at 5: five results drain it without a further error flag ambiguity
        n_vec++; if (credit_ok !== 1'b1) begin n_err++; $display("FAIL sat_credit got %0b want 1", credit_ok); end
    endtask

    task automatic test_reset_midstream;
        do_reset;
        vec_len = 16'd1;
        for (int i = 0; i < 4; i++) push1(16'h3E00 + 16'(i));
        for (int i = 0; i < 2; i++) begin issue_in = 1; step; end
        issue_in = 0;
        ready_in = 1; step; ready_in = 0;
        rst = 1; step; rst = 0;
        n_vec++; if (count_out !== 4'd0 || valid_out !== 1'b0) begin n_err++; $display("FAIL mid_rst got cnt %0d v %0b want 0/0", count_out, valid_out); end
        n_vec++; if (credit_ok !== 1'b1) begin n_err++; $display("FAIL mid_rst_credit got %0b want 1", credit_ok); end
`ifdef SIGMOID_RESBUF_STATS_EN
        n_vec++; if (elem_count_out !== 32'd0 || vec_count_out !== 32'd0) begin n_err++; $display("FAIL mid_rst_stats got %0d/%0d want 0/0", elem_count_out, vec_count_out); end
`endif
        // inflight must have been cleared: 3 entries + 4 issues = 7 leaves credit
        for (int i = 0; i < 3; i++) push1(16'h3D00 + 16'(i));
        for (int i = 0; i < 4; i++) begin issue_in = 1; step; end
        issue_in = 0;
        n_vec++; if (credit_ok !== 1'b1) begin n_err++; $display("FAIL mid_inflight got %0b want 1", credit_ok); end
        issue_in = 1; step; issue_in = 0;
        n_vec++; if (credit_ok !== 1'b0) begin n_err++; $display("FAIL mid_full_credit got %0b want 0", credit_ok); end
    endtask

    initial begin
        rst = 1; issue_in = 0; res_valid_in = 0; res_data_in = 0; ready_in = 0; vec_len = 16'd1;
        test_reset;
        test_credit_stall;
        test_ordering;
        test_last_tag;
        test_overflow;
        test_inflight_errors;
        test_reset_midstream;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_sigmoid_result_buffer
